// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word type and data-memory controller state encoding
//   lc3b_word    : 16-bit machine word / byte address
//   dmem_state_t : IDLE (strobes low), DRAIN (write buffer to memory), LOAD (read for MEM stage)
package lc3b_types;
   typedef logic [15:0] lc3b_word;
   typedef enum logic [1:0] {IDLE, DRAIN, LOAD} dmem_state_t;
endpackage

// File: rtl/byte_lane_fmt.sv
// byte_lane_fmt: byte-lane placement for stores and lane extraction for loads
//   addr_lsb_i : byte address bit 0 (selects lane for byte accesses)
//   byte_i     : 1 = byte access, 0 = word access
//   wdata_i    : raw store data (byte stores use [7:0])
//   rdata_i    : raw memory read word
//   wdata_o    : lane-placed store data
//   be_o       : byte enables, [1]=high lane, [0]=low lane
//   rdata_o    : load result, zero-extended for byte loads
module byte_lane_fmt
   import lc3b_types::*;
(
   input  logic       addr_lsb_i,
   input  logic       byte_i,
   input  lc3b_word   wdata_i,
   input  lc3b_word   rdata_i,
   output lc3b_word   wdata_o,
   output logic [1:0] be_o,
   output lc3b_word   rdata_o
);
   assign be_o    = !byte_i ? 2'b11 : addr_lsb_i ? 2'b10 : 2'b01;
   assign wdata_o = !byte_i ? wdata_i : addr_lsb_i ? {wdata_i[7:0], 8'h00} : {8'h00, wdata_i[7:0]};
   assign rdata_o = !byte_i ? rdata_i : {8'h00, addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0]};
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto the single data-memory port
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_read/req_write          : MEM-stage load/store request (both at once is illegal, treated as read)
//   req_byte/req_addr/req_wdata : access size, byte address, store data
//   req_stall/req_rdata         : pipeline hold, formatted load result
//   mem_*                       : data-memory port (strobes, aligned address, byte enables, data, resp)
//   perf_clear/stall_cnt        : saturating count of stalled cycles with synchronous clear
module dmem_access_ctrl
   import lc3b_types::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_read,
   input  logic             req_write,
   input  logic             req_byte,
   input  lc3b_word         req_addr,
   input  lc3b_word         req_wdata,
   output logic             req_stall,
   output lc3b_word         req_rdata,
   output logic             mem_read,
   output logic             mem_write,
   output lc3b_word         mem_address,
   output logic [1:0]       mem_byte_enable,
   output lc3b_word         mem_wdata,
   input  lc3b_word         mem_rdata,
   input  logic             mem_resp,
   input  logic             perf_clear,
   output logic [CNT_W-1:0] stall_cnt
);
   dmem_state_t      state_q, state_d;
   logic             buf_valid_q, buf_valid_d;
   lc3b_word         buf_addr_q, buf_addr_d, buf_wdata_q, buf_wdata_d;
   logic [1:0]       buf_be_q, buf_be_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   lc3b_word         fmt_wdata, fmt_rdata, req_word_addr;
   logic [1:0]       fmt_be;
   logic             is_write, drain_done, load_done, store_acc;

   byte_lane_fmt u_fmt (
      .addr_lsb_i (req_addr[0]),
      .byte_i     (req_byte),
      .wdata_i    (req_wdata),
      .rdata_i    (mem_rdata),
      .wdata_o    (fmt_wdata),
      .be_o       (fmt_be),
      .rdata_o    (fmt_rdata)
   );

   assign req_word_addr = {req_addr[15:1], 1'b0};
   assign is_write      = req_write && !req_read;
   assign drain_done    = state_q == DRAIN && mem_resp;
   assign load_done     = state_q == LOAD && mem_resp;
   // a store may reload the buffer in the very cycle its previous contents drain
   assign store_acc     = is_write && (!buf_valid_q || drain_done);
   assign stall_cnt     = cnt_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_wdata_q <= '0;
         buf_be_q    <= '0;
         cnt_q       <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_wdata_q <= buf_wdata_d;
         buf_be_q    <= buf_be_d;
         cnt_q       <= cnt_d;
      end

   // the IDLE visit after every response guarantees a strobe-low gap between transactions
   always_comb begin
      state_d     = state_q == IDLE ? (buf_valid_q ? DRAIN : req_read ? LOAD : IDLE) :
                    mem_resp ? IDLE : state_q;
      buf_valid_d = store_acc ? 1'b1 : drain_done ? 1'b0 : buf_valid_q;
      buf_addr_d  = store_acc ? req_word_addr : buf_addr_q;
      buf_wdata_d = store_acc ? fmt_wdata : buf_wdata_q;
      buf_be_d    = store_acc ? fmt_be : buf_be_q;
      cnt_d       = perf_clear ? '0 : (req_stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end

   always_comb begin
      mem_read        = state_q == LOAD;
      mem_write       = state_q == DRAIN;
      mem_address     = mem_write ? buf_addr_q : mem_read ? req_word_addr : '0;
      mem_byte_enable = mem_write ? buf_be_q : mem_read ? fmt_be : '0;
      mem_wdata       = mem_write ? buf_wdata_q : '0;
      req_stall       = req_read ? !load_done : is_write && !store_acc;
      req_rdata       = (req_read && load_done) ? fmt_rdata : '0;
   end

   a_no_rw: assert property (@(posedge clk) disable iff (!rst_n) !(req_read && req_write));
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences all MEM-stage data-memory accesses (LDR/LDB/STR/STB) onto the single data-memory port.
- Generates byte lanes and byte enables, zero-extends LDB results, and stalls the pipeline while the port is busy.
- Posts stores through a one-entry write buffer, so a store stalls only when the buffer is occupied.
- Sits between the MEM stage and the data cache port. Also provides a saturating stall-cycle counter.

Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_read  in  1  MEM stage requests a load
- req_write  in  1  MEM stage requests a store
- req_byte  in  1  1 = byte access (LDB/STB), 0 = word
- req_addr  in  16  lc3b_word byte address
- req_wdata  in  16  store data; STB uses bits [7:0]
- req_stall  out  1  pipeline must hold MEM stage
- req_rdata  out  16  load result, valid when request present and req_stall=0
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  16  word-aligned address
- mem_byte_enable  out  2  lane enables [1]=high, [0]=low
- mem_wdata  out  16  lane-placed write data
- mem_rdata  in  16  memory read data
- mem_resp  in  1  one-cycle completion pulse
- perf_clear  in  1  synchronous clear of stall counter
- stall_cnt  out  CNT_W  saturating count of cycles with req_stall=1

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE; buffer invalid; stall_cnt=0.
  - mem_read, mem_write, mem_address, mem_byte_enable and mem_wdata all 0.
  - Any in-flight transaction is abandoned; the strobes drop immediately.
- Lane rules:
  - mem_address is always {addr[15:1],1'b0}.
  - Word access: be=2'b11; data passes unchanged.
  - Byte access with addr[0]=0: be=2'b01; wdata placed as {8'h00,wdata[7:0]}.
  - Byte access with addr[0]=1: be=2'b10; wdata placed as {wdata[7:0],8'h00}.
  - LDB result: {8'h00, selected lane}. LDR result: mem_rdata.
- Write buffer:
  - Holds address, lane-placed data and be; these are captured at accept time.
  - A store is accepted when the buffer is empty, or in the cycle its drain receives mem_resp. That second case is a simultaneous event: the buffer reloads and stays valid.
  - req_stall=0 in the accept cycle. Otherwise req_stall=1.
- FSM states and transitions:
  - IDLE:
    - buf_valid → DRAIN.
    - Else req_read → LOAD.
    - Strobes are low.
  - DRAIN:
    - mem_write=1 with outputs from the buffer.
    - On mem_resp: clear buf_valid (unless reloaded) → IDLE.
  - LOAD:
    - mem_read=1 with outputs from the request.
    - On mem_resp: req_stall=0, req_rdata formatted combinationally from mem_rdata → IDLE.
- Loads: always wait for an empty buffer (no forwarding). A load stalls through IDLE/DRAIN/IDLE/LOAD until its mem_resp.
- Strobe gap: strobes are low for at least one IDLE cycle between transactions. Back-to-back strobes are never merged.
- Strobe stability: address, be and data stay stable while a strobe is high. mem_resp arriving in IDLE is ignored.
- Illegal input: req_read && req_write is illegal and is covered by an assertion. The RTL treats it as a read.
- No request: req_stall=0 and req_rdata=0.
- stall_cnt:
  - +1 on each cycle with req_stall=1.
  - Saturates at all-ones.
  - perf_clear takes priority over the increment.

Decomposition:
- lc3b_types: lc3b_word, and new enum dmem_state_t {IDLE, DRAIN, LOAD}.
- Sub-module byte_lane_fmt (combinational): computes the placed write data, the byte enable and the extracted load data from the address, the byte flag and the raw data.
- The FSM, write buffer and counter stay in the top module.

Test Plan:
- STR addr 0x3000, wdata 0xBEEF:
  - req_stall=0 in the accept cycle.
  - 2 cycles later: mem_write=1, addr 0x3000, be=11, wdata 0xBEEF.
  - Strobe held until mem_resp.
- STB addr 0x3001, wdata 0x12AB: mem_wdata=0xAB00, be=10, mem_address=0x3000.
- STB addr 0x3000 then STB 0x3004 back-to-back with mem_resp delay 3:
  - Second store stalls until the first store's mem_resp cycle and is accepted in that cycle.
  - mem_write low for exactly 1 cycle, then high with 0x3004.
- LDB addr 0x4001, mem_rdata 0x9A55: req_rdata=0x009A in the mem_resp cycle, req_stall=0 in that cycle only.
- Store then load with the buffer full: mem_read is never asserted before the drain mem_resp, and stall_cnt equals the stalled cycles.
- rst_n low while mem_read=1: strobes drop without waiting for clk; after release, state is IDLE, stall_cnt=0 and buffer empty. A following perf_clear plus a 0xFFFF saturation check confirms stall_cnt holds at 0xFFFF.
